// File: rtl/bus_arbiter4.sv
// ---------------------------------------------------------------------------
// bus_arbiter4
//   Four-way round-robin arbiter for one shared 32-bit bus port. One requester
//   is granted at a time. The grant is held until the slave acknowledges, the
//   requester withdraws, or the watchdog expires. After every release there is
//   one IDLE cycle in which the next winner is chosen.
//
// Parameters
//   TIMEOUT   max BUSY cycles without bus_ack before forced release (0 = off)
//   CNT_W     watchdog counter width (TIMEOUT must be < 2**CNT_W)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   req        in   4  request vector, bit i = requester i
//   bus_ack    in   1  slave completion strobe for the current transaction
//   gnt        out  4  one-hot grant, zero when idle
//   sel        out  2  index of the granted requester (mux select)
//   bus_valid  out  1  transaction active toward the slave
//   timeout    out  1  one-cycle pulse when the watchdog forces release
// ---------------------------------------------------------------------------
module bus_arbiter4 #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       bus_ack,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_valid,
  output logic       timeout
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  // Watchdog is compiled out of the release decision when TIMEOUT is zero.
  localparam bit                WD_EN   = (TIMEOUT != 0);
  localparam int unsigned       TO_LAST_I = (TIMEOUT == 0) ? 0 : (TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TO_LAST_I);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Registered state and outputs.
  state_t             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_bus_valid;
  logic               r_timeout;
  logic [SEL_W-1:0]   r_prio;
  logic [CNT_W-1:0]   r_cnt;

  // Next-state values.
  state_t             w_state_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               w_bus_valid_nxt;
  logic               w_timeout_nxt;
  logic [SEL_W-1:0]   w_prio_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Arbitration result.
  logic               w_win_found;
  logic [SEL_W-1:0]   w_win_idx;

  // BUSY release conditions.
  logic               w_granted_req;
  logic               w_expire;

  // Round-robin pick: first set request scanning prio, prio+1, ... mod 4.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      logic [SEL_W-1:0] cand;
      cand = r_prio + SEL_W'(i);
      if (!w_win_found && req[cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = cand;
      end
    end
  end

  assign w_granted_req = req[r_sel];
  assign w_expire      = WD_EN && (r_cnt == TO_LAST);

  // State and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_sel       <= '0;
      r_bus_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_prio      <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_sel       <= w_sel_nxt;
      r_bus_valid <= w_bus_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_prio      <= w_prio_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_sel_nxt       = r_sel;
    w_bus_valid_nxt = r_bus_valid;
    w_timeout_nxt   = 1'b0;
    w_prio_nxt      = r_prio;
    w_cnt_nxt       = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        // sel is left alone while idle so the mux output stays stable.
        w_gnt_nxt       = '0;
        w_bus_valid_nxt = 1'b0;
        w_cnt_nxt       = '0;
        if (w_win_found) begin
          w_state_nxt     = ST_BUSY;
          w_gnt_nxt       = N_REQ'(1) << w_win_idx;
          w_sel_nxt       = w_win_idx;
          w_bus_valid_nxt = 1'b1;
        end
      end

      ST_BUSY: begin
        // Ack wins over both abort and expiry, so a late ack never pulses timeout.
        if (bus_ack || !w_granted_req || w_expire) begin
          w_state_nxt     = ST_IDLE;
          w_gnt_nxt       = '0;
          w_bus_valid_nxt = 1'b0;
          w_prio_nxt      = r_sel + SEL_W'(1);
          w_cnt_nxt       = '0;
          w_timeout_nxt   = !bus_ack && w_granted_req && w_expire;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = '0;
        w_bus_valid_nxt = 1'b0;
        w_cnt_nxt       = '0;
      end
    endcase
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign bus_valid = r_bus_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_bus_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter4
//   Directed bench for bus_arbiter4. Three instances share one stimulus:
//   TIMEOUT=16 (main), TIMEOUT=0 (watchdog off) and TIMEOUT=4 (collision).
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       bus_ack;

  logic [3:0] gnt,    gnt_t0,    gnt_t4;
  logic [1:0] sel,    sel_t0,    sel_t4;
  logic       bv,     bv_t0,     bv_t4;
  logic       to,     to_t0,     to_t4;

  int n_tests;
  int n_fail;

  bus_arbiter4 #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .bus_ack(bus_ack),
    .gnt(gnt), .sel(sel), .bus_valid(bv), .timeout(to)
  );

  bus_arbiter4 #(.TIMEOUT(0), .CNT_W(8)) dut_t0 (
    .clk(clk), .rst(rst), .req(req), .bus_ack(bus_ack),
    .gnt(gnt_t0), .sel(sel_t0), .bus_valid(bv_t0), .timeout(to_t0)
  );

  bus_arbiter4 #(.TIMEOUT(4), .CNT_W(8)) dut_t4 (
    .clk(clk), .rst(rst), .req(req), .bus_ack(bus_ack),
    .gnt(gnt_t4), .sel(sel_t4), .bus_valid(bv_t4), .timeout(to_t4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = 4'b0000;
    bus_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Structural invariants of the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      check("inv_bv",     32'(bv), 32'(|gnt));
      if (gnt != 4'b0000) check("inv_gnt_sel", 32'(gnt[sel]), 32'd1);
    end
  end

  initial begin
    logic seen_to;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req     = 4'b0000;
    bus_ack = 1'b0;

    // Reset state.
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_bv",  32'(bv),  32'h0);
    check("rst_to",  32'(to),  32'h0);
    do_reset();

    // Ack while idle is ignored.
    bus_ack = 1'b1;
    tick();
    check("idle_ack_gnt", 32'(gnt), 32'h0);
    check("idle_ack_bv",  32'(bv),  32'h0);
    bus_ack = 1'b0;

    // Single requester: grant next edge, ack three cycles later.
    req = 4'b0001;
    tick();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_sel", 32'(sel), 32'h0);
    check("single_bv",  32'(bv),  32'h1);
    tick(); tick(); tick();
    check("single_hold", 32'(gnt), 32'h1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("single_rel_gnt", 32'(gnt), 32'h0);
    check("single_rel_bv",  32'(bv),  32'h0);
    check("single_rel_sel", 32'(sel), 32'h0);
    // prio is now 1: with all requesting, requester 1 wins after the bubble.
    req = 4'b1111;
    tick();
    check("single_prio", 32'(gnt), 32'h2);

    // Round-robin fairness from a fresh reset.
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_sel", 32'(sel), 32'(k % 4));
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      check("rr_bubble", 32'(gnt), 32'h0);
      tick();
    end

    // Priority wrap: serve 2, then 3 wins over 0, then 0.
    do_reset();
    req = 4'b0100;
    tick();
    check("wrap_g2", 32'(gnt), 32'h4);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    req = 4'b1001;
    tick();
    check("wrap_g3",   32'(gnt), 32'h8);
    check("wrap_sel3", 32'(sel), 32'h3);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("wrap_rel_sel", 32'(sel), 32'h3);
    tick();
    check("wrap_g0",   32'(gnt), 32'h1);
    check("wrap_sel0", 32'(sel), 32'h0);

    // Watchdog, TIMEOUT=16: release on the edge ending the 16th BUSY cycle.
    do_reset();
    req = 4'b0100;
    tick();
    check("wd_grant", 32'(gnt), 32'h4);
    for (int n = 1; n <= 15; n++) begin
      tick();
      check("wd_hold_gnt", 32'(gnt), 32'h4);
      check("wd_hold_to",  32'(to),  32'h0);
    end
    tick();
    check("wd_rel_gnt", 32'(gnt), 32'h0);
    check("wd_rel_bv",  32'(bv),  32'h0);
    check("wd_pulse",   32'(to),  32'h1);
    req = 4'b1100;
    tick();
    check("wd_pulse_end", 32'(to),  32'h0);
    check("wd_prio3",     32'(gnt), 32'h8);

    // Watchdog disabled: grant holds 100 cycles with no pulse.
    do_reset();
    req = 4'b0100;
    tick();
    seen_to = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      seen_to = seen_to | to_t0;
    end
    check("wd0_hold", 32'(gnt_t0), 32'h4);
    check("wd0_noto", 32'(seen_to), 32'h0);

    // TIMEOUT=4 without ack: forced release after 4 BUSY cycles.
    do_reset();
    req = 4'b0001;
    tick();
    tick(); tick(); tick();
    check("t4_hold", 32'(gnt_t4), 32'h1);
    tick();
    check("t4_rel", 32'(gnt_t4), 32'h0);
    check("t4_to",  32'(to_t4),  32'h1);

    // TIMEOUT=4 with ack in the cnt==3 cycle: plain release, no pulse.
    do_reset();
    req = 4'b0001;
    tick();
    tick(); tick(); tick();
    check("coll_hold", 32'(gnt_t4), 32'h1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("coll_rel", 32'(gnt_t4), 32'h0);
    check("coll_to",  32'(to_t4),  32'h0);

    // Requester abort: release next edge, no pulse.
    do_reset();
    req = 4'b0010;
    tick();
    check("abort_grant", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_to",  32'(to),  32'h0);

    // Async reset mid-BUSY clears outputs without a clock edge.
    do_reset();
    req = 4'b0100;
    tick();
    check("arst_pre_sel", 32'(sel), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_bv",  32'(bv),  32'h0);
    check("arst_sel", 32'(sel), 32'h0);
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check("arst_prio0", 32'(gnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
